// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: prioritises trap sources, issues CSR writes one per cycle, then redirects fetch.
// Optional feature macro: TRAP_SEQ_VECTORED_EN (vectored interrupt targets when mtvec.MODE == 01).
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_V,
  input  logic [XLEN-1:0] WB_PC,
  input  logic [31:0]     WB_IR,
  input  logic            WB_ECALL,
  input  logic            WB_MRET,
  input  logic            F_IAM,
  input  logic            F_IAF,
  input  logic            F_II,
  input  logic            MEM_LAM,
  input  logic            MEM_LAF,
  input  logic            MEM_SAM,
  input  logic            MEM_SAF,
  input  logic [XLEN-1:0] MEM_ADDR,
  input  logic            TIMER,
  input  logic            EXTERNAL,
  input  logic            PRIVILEGE,
  input  logic [XLEN-1:0] CSR_MSTATUS,
  input  logic [XLEN-1:0] CSR_MIE,
  input  logic [XLEN-1:0] CSR_MTVEC,
  input  logic [XLEN-1:0] CSR_MEPC,
  output logic            TS_KILL,
  output logic            TS_STALL,
  output logic            TS_FLUSH,
  output logic            TS_CSR_WE,
  output logic [11:0]     TS_CSR_ADDR,
  output logic [XLEN-1:0] TS_CSR_WDATA,
  output logic            TS_PC_MUX,
  output logic [XLEN-1:0] TS_TARGET,
  output logic [XLEN-1:0] TS_CAUSE
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIRECT
  } state_e;

  localparam logic [XLEN-1:0] INT_BIT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            priv_q, priv_d;
  logic            is_mret_q, is_mret_d;

  logic            int_en;
  logic            trap_hit;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            accept_trap;
  logic            accept_mret;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  assign int_en = CSR_MSTATUS[3] | ~PRIVILEGE;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    trap_hit   = 1'b1;
    trap_cause = '0;
    trap_tval  = '0;
    if (EXTERNAL && CSR_MIE[11] && int_en) begin
      trap_cause = INT_BIT | XLEN'(11);
    end else if (TIMER && CSR_MIE[7] && int_en) begin
      trap_cause = INT_BIT | XLEN'(7);
    end else if (F_IAF) begin
      trap_cause = XLEN'(1);
      trap_tval  = WB_PC;
    end else if (F_II) begin
      trap_cause = XLEN'(2);
      trap_tval  = {{(XLEN-32){1'b0}}, WB_IR};
    end else if (F_IAM) begin
      trap_cause = XLEN'(0);
      trap_tval  = WB_PC;
    end else if (WB_ECALL) begin
      trap_cause = PRIVILEGE ? XLEN'(11) : XLEN'(8);
    end else if (MEM_SAM) begin
      trap_cause = XLEN'(6);
      trap_tval  = MEM_ADDR;
    end else if (MEM_LAM) begin
      trap_cause = XLEN'(4);
      trap_tval  = MEM_ADDR;
    end else if (MEM_SAF) begin
      trap_cause = XLEN'(7);
      trap_tval  = MEM_ADDR;
    end else if (MEM_LAF) begin
      trap_cause = XLEN'(5);
      trap_tval  = MEM_ADDR;
    end else begin
      trap_hit = 1'b0;
    end
  end

  assign accept_trap = (state_q == IDLE) && WB_V && trap_hit;
  assign accept_mret = (state_q == IDLE) && WB_V && WB_MRET && !trap_hit;
  assign TS_KILL     = !RESET && (accept_trap || accept_mret);

  always_comb begin
    mstatus_trap        = CSR_MSTATUS;
    mstatus_trap[7]     = CSR_MSTATUS[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = {2{priv_q}};
    mstatus_mret        = CSR_MSTATUS;
    mstatus_mret[3]     = CSR_MSTATUS[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b00;
  end

  assign trap_base = {CSR_MTVEC[XLEN-1:2], 2'b00};

`ifdef TRAP_SEQ_VECTORED_EN
  // Only interrupts are vectored; exceptions always land on the base.
  assign trap_target = (CSR_MTVEC[1:0] == 2'b01 && cause_q[XLEN-1])
                     ? trap_base + XLEN'({cause_q[5:0], 2'b00})
                     : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    tval_d       = tval_q;
    priv_d       = priv_q;
    is_mret_d    = is_mret_q;
    TS_FLUSH     = 1'b0;
    TS_CSR_WE    = 1'b0;
    TS_CSR_ADDR  = 12'h000;
    TS_CSR_WDATA = '0;
    TS_PC_MUX    = 1'b0;
    TS_TARGET    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_trap) begin
          pc_d      = WB_PC;
          cause_d   = trap_cause;
          tval_d    = trap_tval;
          priv_d    = PRIVILEGE;
          is_mret_d = 1'b0;
          state_d   = W_EPC;
        end else if (accept_mret) begin
          is_mret_d = 1'b1;
          state_d   = R_STATUS;
        end
      end
      W_EPC: begin
        TS_CSR_WE    = 1'b1;
        TS_CSR_ADDR  = 12'h341;
        TS_CSR_WDATA = pc_q;
        state_d      = W_CAUSE;
      end
      W_CAUSE: begin
        TS_CSR_WE    = 1'b1;
        TS_CSR_ADDR  = 12'h342;
        TS_CSR_WDATA = cause_q;
        state_d      = W_TVAL;
      end
      W_TVAL: begin
        TS_CSR_WE    = 1'b1;
        TS_CSR_ADDR  = 12'h343;
        TS_CSR_WDATA = tval_q;
        state_d      = W_STATUS;
      end
      W_STATUS: begin
        TS_CSR_WE    = 1'b1;
        TS_CSR_ADDR  = 12'h300;
        TS_CSR_WDATA = mstatus_trap;
        state_d      = REDIRECT;
      end
      R_STATUS: begin
        TS_CSR_WE    = 1'b1;
        TS_CSR_ADDR  = 12'h300;
        TS_CSR_WDATA = mstatus_mret;
        state_d      = REDIRECT;
      end
      REDIRECT: begin
        TS_PC_MUX = 1'b1;
        TS_FLUSH  = 1'b1;
        TS_TARGET = is_mret_q ? CSR_MEPC : trap_target;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign TS_STALL = (state_q != IDLE);
  assign TS_CAUSE = cause_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      priv_q    <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      priv_q    <= priv_d;
      is_mret_q <= is_mret_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes expected CSR writes / redirects, a negedge monitor pops and compares.
module tb_trap_sequencer;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_V, WB_ECALL, WB_MRET;
  logic [63:0] WB_PC, MEM_ADDR;
  logic [31:0] WB_IR;
  logic        F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
  logic        TIMER, EXTERNAL, PRIVILEGE;
  logic [63:0] CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC;
  logic        TS_KILL, TS_STALL, TS_FLUSH, TS_CSR_WE, TS_PC_MUX;
  logic [11:0] TS_CSR_ADDR;
  logic [63:0] TS_CSR_WDATA, TS_TARGET, TS_CAUSE;

  always #5 CLK = ~CLK;

  trap_sequencer #(.XLEN(64)) dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .WB_IR(WB_IR),
    .WB_ECALL(WB_ECALL), .WB_MRET(WB_MRET), .F_IAM(F_IAM), .F_IAF(F_IAF), .F_II(F_II),
    .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
    .MEM_ADDR(MEM_ADDR), .TIMER(TIMER), .EXTERNAL(EXTERNAL), .PRIVILEGE(PRIVILEGE),
    .CSR_MSTATUS(CSR_MSTATUS), .CSR_MIE(CSR_MIE), .CSR_MTVEC(CSR_MTVEC), .CSR_MEPC(CSR_MEPC),
    .TS_KILL(TS_KILL), .TS_STALL(TS_STALL), .TS_FLUSH(TS_FLUSH), .TS_CSR_WE(TS_CSR_WE),
    .TS_CSR_ADDR(TS_CSR_ADDR), .TS_CSR_WDATA(TS_CSR_WDATA), .TS_PC_MUX(TS_PC_MUX),
    .TS_TARGET(TS_TARGET), .TS_CAUSE(TS_CAUSE)
  );

  typedef struct {
    bit          redir;
    logic [11:0] addr;
    logic [63:0] data;
    logic [63:0] cause;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [63:0] last_cause = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sources listed in priority order, first pending one wins.
  function automatic void model(output int kind, output logic [63:0] cause, output logic [63:0] tval);
    bit          ie;
    bit          pend[10];
    logic [63:0] cz[10];
    logic [63:0] tv[10];
    ie = CSR_MSTATUS[3] || !PRIVILEGE;
    pend = '{EXTERNAL && CSR_MIE[11] && ie, TIMER && CSR_MIE[7] && ie, F_IAF, F_II, F_IAM,
             WB_ECALL, MEM_SAM, MEM_LAM, MEM_SAF, MEM_LAF};
    cz = '{64'h8000_0000_0000_000B, 64'h8000_0000_0000_0007, 64'd1, 64'd2, 64'd0,
           PRIVILEGE ? 64'd11 : 64'd8, 64'd6, 64'd4, 64'd7, 64'd5};
    tv = '{64'd0, 64'd0, WB_PC, {32'd0, WB_IR}, WB_PC, 64'd0, MEM_ADDR, MEM_ADDR, MEM_ADDR, MEM_ADDR};
    kind  = 0;
    cause = '0;
    tval  = '0;
    if (!WB_V) return;
    for (int i = 0; i < 10; i++) begin
      if (pend[i]) begin
        kind  = 1;
        cause = cz[i];
        tval  = tv[i];
        return;
      end
    end
    if (WB_MRET) kind = 2;
  endfunction

  function automatic logic [63:0] exp_target(input logic [63:0] cause, input logic [63:0] mtvec);
    logic [63:0] base;
    base = mtvec & ~64'h3;
`ifdef TRAP_SEQ_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause[63]) base = base + 4 * (cause & 64'h3F);
`endif
    return base;
  endfunction

  function automatic logic [63:0] ms_trap(input logic [63:0] ms, input logic priv);
    return (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | (priv ? 64'h1800 : 64'h0);
  endfunction

  function automatic logic [63:0] ms_mret(input logic [63:0] ms);
    return (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
  endfunction

  // Monitor: compares every CSR write / redirect the DUT presents against the scoreboard head.
  always @(negedge CLK) begin
    if (!RESET) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("event_missing_cycle", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
      check("stall_vs_activity", 64'(TS_STALL), 64'(TS_CSR_WE | TS_PC_MUX));
      check("flush_vs_pcmux", 64'(TS_FLUSH), 64'(TS_PC_MUX));
      if (TS_CSR_WE || TS_PC_MUX) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {62'd0, TS_CSR_WE, TS_PC_MUX}, 64'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("event_is_redirect", 64'(TS_PC_MUX), 64'(e.redir));
          if (e.redir) begin
            check("redirect_target", TS_TARGET, e.data);
            check("redirect_cause", TS_CAUSE, e.cause);
          end else begin
            check("csr_addr", 64'(TS_CSR_ADDR), 64'(e.addr));
            check("csr_wdata", TS_CSR_WDATA, e.data);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    WB_V = 0; WB_PC = '0; WB_IR = '0; WB_ECALL = 0; WB_MRET = 0;
    F_IAM = 0; F_IAF = 0; F_II = 0; MEM_LAM = 0; MEM_LAF = 0; MEM_SAM = 0; MEM_SAF = 0;
    MEM_ADDR = '0; TIMER = 0; EXTERNAL = 0; PRIVILEGE = 0;
    CSR_MSTATUS = '0; CSR_MIE = '0; CSR_MTVEC = '0; CSR_MEPC = '0;
  endtask

  // Non-CSR inputs only: CSRs are held stable while a sequence is in flight.
  task automatic noise();
    WB_V = 1'($urandom); WB_PC = {$urandom, $urandom}; WB_IR = $urandom;
    WB_ECALL = ($urandom_range(0, 3) == 0); WB_MRET = ($urandom_range(0, 3) == 0);
    F_IAM = ($urandom_range(0, 5) == 0); F_IAF = ($urandom_range(0, 5) == 0);
    F_II = ($urandom_range(0, 5) == 0); MEM_LAM = ($urandom_range(0, 5) == 0);
    MEM_LAF = ($urandom_range(0, 5) == 0); MEM_SAM = ($urandom_range(0, 5) == 0);
    MEM_SAF = ($urandom_range(0, 5) == 0); MEM_ADDR = {$urandom, $urandom};
    TIMER = ($urandom_range(0, 3) == 0); EXTERNAL = ($urandom_range(0, 3) == 0);
    PRIVILEGE = 1'($urandom);
  endtask

  task automatic randomize_inputs();
    noise();
    WB_V = ($urandom_range(0, 7) != 0);
    F_IAM = ($urandom_range(0, 9) == 0); F_IAF = ($urandom_range(0, 9) == 0);
    F_II = ($urandom_range(0, 9) == 0); MEM_LAM = ($urandom_range(0, 9) == 0);
    MEM_LAF = ($urandom_range(0, 9) == 0); MEM_SAM = ($urandom_range(0, 9) == 0);
    MEM_SAF = ($urandom_range(0, 9) == 0); WB_ECALL = ($urandom_range(0, 9) == 0);
    CSR_MSTATUS = {$urandom, $urandom};
    CSR_MIE = {$urandom, $urandom};
    CSR_MTVEC = {$urandom, $urandom & 32'hFFFF_FFFC} | 64'($urandom_range(0, 1));
    CSR_MEPC = {$urandom, $urandom};
  endtask

  task automatic push_expected(input int kind, input logic [63:0] cause, input logic [63:0] tval,
                               input int unsigned c);
    if (kind == 1) begin
      sb.push_back('{1'b0, 12'h341, WB_PC, 64'd0, c + 1});
      sb.push_back('{1'b0, 12'h342, cause, 64'd0, c + 2});
      sb.push_back('{1'b0, 12'h343, tval, 64'd0, c + 3});
      sb.push_back('{1'b0, 12'h300, ms_trap(CSR_MSTATUS, PRIVILEGE), 64'd0, c + 4});
      sb.push_back('{1'b1, 12'h000, exp_target(cause, CSR_MTVEC), cause, c + 5});
      last_cause = cause;
    end else if (kind == 2) begin
      sb.push_back('{1'b0, 12'h300, ms_mret(CSR_MSTATUS), 64'd0, c + 1});
      sb.push_back('{1'b1, 12'h000, CSR_MEPC, last_cause, c + 2});
    end
  endtask

  // Called at posedge+1 with the candidate instruction already on the inputs.
  task automatic run_txn();
    int          kind;
    int          busy;
    logic [63:0] cause, tval;
    model(kind, cause, tval);
    push_expected(kind, cause, tval, cyc);
    @(negedge CLK);
    check("kill_on_accept", 64'(TS_KILL), 64'(kind != 0));
    @(posedge CLK); #1;
    busy = (kind == 1) ? 5 : (kind == 2) ? 2 : 0;
    for (int i = 0; i < busy; i++) begin
      if (i == 0 && kind == 1) check("cause_latched", TS_CAUSE, cause);
      noise();
      @(negedge CLK);
      check("kill_while_busy", 64'(TS_KILL), 64'd0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RESET = 1'b1;
    WB_V = 1'b1; F_IAF = 1'b1; WB_MRET = 1'b1;
    #1;
    check("reset_kill", 64'(TS_KILL), 64'd0);
    check("reset_stall", 64'(TS_STALL), 64'd0);
    check("reset_flush", 64'(TS_FLUSH), 64'd0);
    check("reset_csr_we", 64'(TS_CSR_WE), 64'd0);
    check("reset_csr_addr", 64'(TS_CSR_ADDR), 64'd0);
    check("reset_csr_wdata", TS_CSR_WDATA, 64'd0);
    check("reset_pc_mux", 64'(TS_PC_MUX), 64'd0);
    check("reset_target", TS_TARGET, 64'd0);
    check("reset_cause", TS_CAUSE, 64'd0);
    repeat (3) @(posedge CLK);
    clear_inputs();
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;

    // ECALL from U-mode
    clear_inputs();
    WB_V = 1; WB_ECALL = 1; WB_PC = 64'h1000; CSR_MTVEC = 64'h8000_0000; CSR_MSTATUS = 64'h8;
    run_txn();
    check("ecall_u_cause", TS_CAUSE, 64'd8);

    // Illegal instruction
    clear_inputs();
    WB_V = 1; F_II = 1; WB_IR = 32'hFFFF_FFFF; PRIVILEGE = 1; CSR_MTVEC = 64'h8000_0000;
    run_txn();
    check("illegal_cause", TS_CAUSE, 64'd2);

    // External beats load misaligned when enabled
    clear_inputs();
    WB_V = 1; MEM_LAM = 1; EXTERNAL = 1; CSR_MIE = 64'h800; CSR_MSTATUS = 64'h8; PRIVILEGE = 1;
    MEM_ADDR = 64'h1234_5678_9ABC_DEF0; CSR_MTVEC = 64'h8000_0000;
    run_txn();
    check("ext_priority_cause", TS_CAUSE, 64'h8000_0000_0000_000B);

    // Same with MIE=0 in M-mode: interrupt masked
    clear_inputs();
    WB_V = 1; MEM_LAM = 1; EXTERNAL = 1; CSR_MIE = 64'h800; CSR_MSTATUS = 64'h0; PRIVILEGE = 1;
    MEM_ADDR = 64'h1234_5678_9ABC_DEF0; CSR_MTVEC = 64'h8000_0000;
    run_txn();
    check("masked_ext_cause", TS_CAUSE, 64'd4);

    // Timer with vectored mtvec
    clear_inputs();
    WB_V = 1; TIMER = 1; CSR_MIE = 64'h80; CSR_MSTATUS = 64'h8; PRIVILEGE = 1;
    CSR_MTVEC = 64'h8000_0001;
    run_txn();

    // MRET
    clear_inputs();
    WB_V = 1; WB_MRET = 1; PRIVILEGE = 1; CSR_MSTATUS = 64'h1880; CSR_MEPC = 64'h2004;
    run_txn();
    check("cause_held_after_mret", TS_CAUSE, 64'h8000_0000_0000_0007);

    // Reset while in W_CAUSE
    clear_inputs();
    WB_V = 1; F_IAM = 1; WB_PC = 64'h4000; CSR_MTVEC = 64'h8000_0000; CSR_MSTATUS = 64'h8;
    push_expected(1, 64'd0, 64'h4000, cyc);
    @(posedge CLK); #1;
    clear_inputs();
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    RESET = 1'b1;
    #1;
    check("midreset_stall", 64'(TS_STALL), 64'd0);
    check("midreset_csr_we", 64'(TS_CSR_WE), 64'd0);
    check("midreset_csr_addr", 64'(TS_CSR_ADDR), 64'd0);
    check("midreset_csr_wdata", TS_CSR_WDATA, 64'd0);
    check("midreset_pc_mux", 64'(TS_PC_MUX), 64'd0);
    check("midreset_flush", 64'(TS_FLUSH), 64'd0);
    check("midreset_cause", TS_CAUSE, 64'd0);
    sb.delete();
    last_cause = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    repeat (6) begin
      @(negedge CLK);
      check("post_reset_idle_stall", 64'(TS_STALL), 64'd0);
      @(posedge CLK); #1;
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      run_txn();
    end

    clear_inputs();
    repeat (8) @(posedge CLK);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
